// File: rtl/case_fold_framer.sv
// case_fold_framer: folds a-z to A-Z and packs MSG_LEN chars plus a case map into one frame.
// Optional STRICT_ALPHA_EN drops non-letters and counts them in err_count.
module case_fold_framer #(
  parameter int MSG_LEN = 6,
  parameter logic [7:0] PAD_CHAR = 8'h20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_char,
  input  logic                         in_last,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic [8*MSG_LEN-1:0]         frame_data,
  output logic [MSG_LEN-1:0]           frame_case,
  output logic [$clog2(MSG_LEN+1)-1:0] frame_len,
  output logic [7:0]                   err_count
);
  localparam int LW = $clog2(MSG_LEN + 1);
  typedef enum logic {FILL, FULL} state_t;
  state_t state;
  logic [LW-1:0] idx, nidx;
  logic accept, lower, keep, store, close;
  assign in_ready = (state == FILL) && rst_n;
  assign accept = in_valid && in_ready;
  assign lower = in_char >= 8'h61 && in_char <= 8'h7a;
`ifdef STRICT_ALPHA_EN
  assign keep = lower || (in_char >= 8'h41 && in_char <= 8'h5a);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_count <= '0;
    else if (accept && !keep && err_count != 8'hff) err_count <= err_count + 8'd1;
`else
  assign keep = 1'b1;
  assign err_count = '0;
`endif
  assign store = accept && keep;
  assign nidx = idx + LW'(store);
  // a drop with in_last only closes when something is already stored
  assign close = (store && idx == LW'(MSG_LEN - 1)) || (accept && in_last && nidx != '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      idx <= '0;
      frame_valid <= 1'b0;
      frame_data <= '0;
      frame_case <= '0;
      frame_len <= '0;
    end else if (state == FULL) begin
      if (frame_ready) begin
        state <= FILL;
        idx <= '0;
        frame_valid <= 1'b0;
        frame_data <= '0;
        frame_case <= '0;
        frame_len <= '0;
      end
    end else begin
      idx <= nidx;
      for (int j = 0; j < MSG_LEN; j++)
        if (store && idx == LW'(j)) begin
          frame_data[8*j +: 8] <= lower ? in_char - 8'd32 : in_char;
          frame_case[j] <= lower;
        end else if (close && LW'(j) >= nidx) begin
          frame_data[8*j +: 8] <= PAD_CHAR;
          frame_case[j] <= 1'b0;
        end
      if (close) begin
        state <= FULL;
        frame_valid <= 1'b1;
        frame_len <= nidx;
      end
    end
  end
endmodule

// File: tb/tb_case_fold_framer.sv
// tb_case_fold_framer: directed checks of folding, padding, backpressure and async reset.
module tb_case_fold_framer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, frame_ready = 1'b1;
  logic [7:0] in_char = '0;
  logic in_ready, frame_valid;
  logic [47:0] frame_data;
  logic [5:0] frame_case;
  logic [2:0] frame_len;
  logic [7:0] err_count;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  case_fold_framer #(.MSG_LEN(6), .PAD_CHAR(8'h20)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_last(in_last), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_data(frame_data), .frame_case(frame_case),
    .frame_len(frame_len), .err_count(err_count)
  );
  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      chk("fill_ready", 48'(in_ready), 48'd1);
      chk("fill_no_valid", 48'(frame_valid), 48'd0);
      in_valid = 1'b1;
      in_char = s[i];
      in_last = last && i == s.len() - 1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic chk_frame(input string tag, input logic [47:0] d, input logic [5:0] c, input logic [2:0] l);
    chk({tag, "_valid"}, 48'(frame_valid), 48'd1);
    chk({tag, "_data"}, frame_data, d);
    chk({tag, "_case"}, 48'(frame_case), 48'(c));
    chk({tag, "_len"}, 48'(frame_len), 48'(l));
  endtask
  initial begin
    #1;
    chk("rst_ready", 48'(in_ready), 48'd0);
    chk("rst_valid", 48'(frame_valid), 48'd0);
    chk("rst_data", frame_data, 48'd0);
    chk("rst_len", 48'(frame_len), 48'd0);
    chk("rst_err", 48'(err_count), 48'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_str("HeLloW", 1'b0);
    chk_frame("t1", 48'h574F4C4C4548, 6'b011010, 3'd6);
    @(negedge clk);
    chk("t1_one_cycle", 48'(frame_valid), 48'd0);
    frame_ready = 1'b0;
    send_str("ABCDEF", 1'b0);
    in_valid = 1'b1;
    in_char = "Z";
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_ready", 48'(in_ready), 48'd0);
      chk_frame("t2_hold", 48'h464544434241, 6'b0, 3'd6);
      @(negedge clk);
    end
    in_valid = 1'b0;
    frame_ready = 1'b1;
    @(negedge clk);
    chk("t2_released", 48'(frame_valid), 48'd0);
    send_str("GHIJKL", 1'b0);
    chk_frame("t2_next", 48'h4C4B4A494847, 6'b0, 3'd6);
    send_str("abc", 1'b1);
    chk_frame("t3", 48'h202020434241, 6'b000111, 3'd3);
`ifdef STRICT_ALPHA_EN
    send_str("a1Bz!c", 1'b1);
    chk_frame("t4s", 48'h2020435A4241, 6'b001101, 3'd4);
    chk("t4s_err", 48'(err_count), 48'd2);
`else
    send_str("a1 z!Q", 1'b0);
    chk_frame("t4", 48'h51215A203141, 6'b001001, 3'd6);
    chk("t4_err", 48'(err_count), 48'd0);
`endif
    send_str("QWE", 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ready", 48'(in_ready), 48'd0);
    chk("t5_valid", 48'(frame_valid), 48'd0);
    chk("t5_data", frame_data, 48'd0);
    chk("t5_case", 48'(frame_case), 48'd0);
    chk("t5_len", 48'(frame_len), 48'd0);
    chk("t5_err", 48'(err_count), 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_str("QWERTY", 1'b0);
    chk_frame("t5_clean", 48'h595452455751, 6'b0, 3'd6);
    send_str("ABCDEF", 1'b1);
    chk_frame("t6", 48'h464544434241, 6'b0, 3'd6);
    @(negedge clk);
    chk("t6_single_a", 48'(frame_valid), 48'd0);
    @(negedge clk);
    chk("t6_single_b", 48'(frame_valid), 48'd0);
    send_str("x", 1'b1);
    chk_frame("t6_new", 48'h202020202058, 6'b000001, 3'd1);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
